ctrl_mem_dados: RTL
===================

CTRL_MEM_DADOS -- requirements
Module: ctrl_mem_dados

Interface
REQ-001 Parameters SHALL be:
  - DATA_W, 32, data/PC width.
  - MEM_DEPTH, 64, data-memory words.
  - OS_LIMIT, 687, highest OS instruction position.
  - CTX_SLOT, 63, memory word reserved for the saved PC.
REQ-002 Ports SHALL be:
  - clk  in  1  single clock, rising edge.
  - rst_n  in  1  asynchronous active-low reset.
  - cpu_req  in  1  CPU access request; held until cpu_gnt.
  - cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
  - cpu_addr  in  32  CPU word address.
  - cpu_wdata  in  32  CPU write data.
  - cpu_gnt  out  1  one-cycle pulse; CPU access accepted this cycle.
  - cpu_valid  out  1  one-cycle pulse; cpu_rdata valid / write done.
  - cpu_rdata  out  32  registered read data.
  - pos_atual  in  32  current program position.
  - end_atual  in  32  current PC value to save.
  - fim_prog  in  1  program-end strobe.
  - mem_we  out  1  data-memory write enable.
  - mem_addr  out  6  data-memory address.
  - mem_wdata  out  32  data-memory write data.
  - mem_rdata  in  32  data-memory combinational read data.
  - saida_pc  out  32  last saved PC.
  - ctx_busy  out  1  context save in progress.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, CPU_ACC, CPU_RESP and CTX_SAVE.
REQ-004 The block SHALL generate a save trigger when pos_atual > OS_LIMIT (unsigned) on a cycle where the registered value of that comparison was 0 (OS exit edge), or when fim_prog = 1.
REQ-005 A trigger arriving while not in IDLE SHALL set a single pending flag; further triggers SHALL NOT queue beyond one.
REQ-006 In IDLE, a trigger or a pending flag SHALL take priority over cpu_req and move the FSM to CTX_SAVE; cpu_gnt SHALL stay 0 in that cycle.
REQ-007 In CTX_SAVE the block SHALL, for one cycle, drive mem_we = 1, mem_addr = CTX_SLOT and mem_wdata = end_atual, load saida_pc with end_atual, and hold ctx_busy = 1. It SHALL clear pending and return to IDLE.
REQ-008 In IDLE with cpu_req = 1 and no trigger or pending flag, the block SHALL pulse cpu_gnt, register cpu_we, cpu_addr and cpu_wdata, and go to CPU_ACC.
REQ-009 In CPU_ACC the block SHALL drive mem_addr = registered cpu_addr[5:0]. For a write it SHALL also drive mem_we = 1 and mem_wdata = registered cpu_wdata. For a read it SHALL capture mem_rdata into cpu_rdata. The FSM SHALL then go to CPU_RESP.
REQ-010 In CPU_RESP the block SHALL pulse cpu_valid and return to IDLE. Request-to-valid latency SHALL be 2 cycles after cpu_gnt.
REQ-011 A CPU address >= MEM_DEPTH SHALL suppress mem_we, return cpu_rdata = 0, and still complete with cpu_valid.
REQ-012 A CPU write to CTX_SLOT SHALL be performed normally, with no protection.
REQ-013 mem_we SHALL be 0 in every state except the cases stated in REQ-007 and REQ-009.
REQ-014 Back-to-back CPU requests SHALL be granted at most once every 3 cycles. A CPU access in progress SHALL NOT be aborted by a trigger.

Reset
REQ-015 rst_n = 0 SHALL immediately force the FSM to IDLE, clear the pending flag and the edge register, and drive cpu_gnt, cpu_valid, mem_we and ctx_busy to 0 and cpu_rdata, saida_pc and mem_addr to 0.
REQ-016 Reset asserted mid-access or mid-save SHALL abandon that operation with no memory write in the reset cycle. After release the FSM SHALL resume from IDLE.

Structure
REQ-017 DATA_W, MEM_DEPTH, OS_LIMIT, CTX_SLOT and the state encoding SHALL live in a shared package (proc_pkg).
REQ-018 The edge and pending trigger logic SHALL be a sub-module, ctx_trigger, with outputs trig and pending.
REQ-019 The implementation SHALL be 120-400 lines of RTL with no latches and all outputs registered except mem_we, mem_addr and mem_wdata.

Verification
REQ-020 Bench scenario: CPU write addr 5, data 0xDEADBEEF, then read addr 5 -> cpu_gnt, then cpu_valid 2 cycles later; cpu_rdata = 0xDEADBEEF.
REQ-021 Bench scenario: pos_atual steps 687 -> 688 with end_atual = 0x2B4 -> one CTX_SAVE cycle; mem write to addr 63 of 0x2B4; saida_pc = 0x2B4. Holding pos_atual at 688 SHALL produce no second save.
REQ-022 Bench scenario: cpu_req and fim_prog asserted in the same cycle -> CTX_SAVE first, cpu_gnt one cycle later, then cpu_valid.
REQ-023 Bench scenario: fim_prog pulsed twice during a CPU access -> exactly one save after the access completes.
REQ-024 Bench scenario: CPU read of addr 100 -> cpu_valid with cpu_rdata = 0; CPU write to addr 100 -> no mem_we.
REQ-025 Bench scenario: rst_n pulled low during CPU_ACC of a write -> no mem_we; all outputs 0; a new request after release completes normally.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared constants and FSM encoding for the data-memory controller.
package proc_pkg;

    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 64;
    localparam int OS_LIMIT  = 687;
    localparam int CTX_SLOT  = 63;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_ACC  = 2'd1,
        CPU_RESP = 2'd2,
        CTX_SAVE = 2'd3
    } state_e;

endpackage

// File: rtl/ctx_trigger.sv
// Context-save trigger: OS-exit edge detect or program-end strobe,
// with a single-entry pending flag for triggers that arrive while the FSM is busy.
module ctx_trigger #(
    parameter int DATA_W   = proc_pkg::DATA_W,
    parameter int OS_LIMIT = proc_pkg::OS_LIMIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pos_atual,
    input  logic              fim_prog,
    input  logic              fsm_idle,
    input  logic              save_done,
    output logic              trig,
    output logic              pending
);

    logic in_user;
    logic in_user_d, in_user_q;
    logic pending_d, pending_q;

    assign in_user = pos_atual > DATA_W'(OS_LIMIT);

    // NOTE: every always_comb output gets a value before any branch, so no latch can be inferred.
    always_comb begin
        trig      = (in_user && !in_user_q) || fim_prog;
        in_user_d = in_user;
        // A fresh trigger during the save cycle must survive the clear.
        pending_d = (trig && !fsm_idle) || (pending_q && !save_done);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_user_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            in_user_q <= in_user_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/ctrl_mem_dados.sv
// Data-memory controller: arbitrates CPU word accesses against PC context saves
// into a reserved memory slot.
module ctrl_mem_dados #(
    parameter int  DATA_W    = proc_pkg::DATA_W,
    parameter int  MEM_DEPTH = proc_pkg::MEM_DEPTH,
    parameter int  OS_LIMIT  = proc_pkg::OS_LIMIT,
    parameter int  CTX_SLOT  = proc_pkg::CTX_SLOT,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_valid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic [DATA_W-1:0] pos_atual,
    input  logic [DATA_W-1:0] end_atual,
    input  logic              fim_prog,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] saida_pc,
    output logic              ctx_busy
);

    import proc_pkg::*;

    state_e            state_d, state_q;
    logic              we_d, we_q;
    logic [DATA_W-1:0] addr_d, addr_q;
    logic [DATA_W-1:0] wdata_d, wdata_q;
    logic              cpu_gnt_d, cpu_gnt_q;
    logic              cpu_valid_d, cpu_valid_q;
    logic [DATA_W-1:0] cpu_rdata_d, cpu_rdata_q;
    logic [DATA_W-1:0] saida_pc_d, saida_pc_q;
    logic              ctx_busy_d, ctx_busy_q;
    logic              trig, pending, in_range;

    ctx_trigger #(
        .DATA_W   (DATA_W),
        .OS_LIMIT (OS_LIMIT)
    ) u_ctx_trigger (
        .clk       (clk),
        .rst_n     (rst_n),
        .pos_atual (pos_atual),
        .fim_prog  (fim_prog),
        .fsm_idle  (state_q == IDLE),
        .save_done (state_q == CTX_SAVE),
        .trig      (trig),
        .pending   (pending)
    );

    assign in_range = addr_q < DATA_W'(MEM_DEPTH);

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_gnt_d   = 1'b0;
        cpu_valid_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        saida_pc_d  = saida_pc_q;
        ctx_busy_d  = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        unique case (state_q)
            IDLE: begin
                if (trig || pending) begin
                    state_d    = CTX_SAVE;
                    ctx_busy_d = 1'b1;
                end else if (cpu_req) begin
                    state_d   = CPU_ACC;
                    cpu_gnt_d = 1'b1;
                    we_d      = cpu_we;
                    addr_d    = cpu_addr;
                    wdata_d   = cpu_wdata;
                end
            end
            CPU_ACC: begin
                mem_addr = addr_q[AW-1:0];
                if (we_q) begin
                    mem_we    = in_range;
                    mem_wdata = wdata_q;
                end else begin
                    // Out-of-range reads return zero rather than an aliased word.
                    cpu_rdata_d = in_range ? mem_rdata : '0;
                end
                state_d = CPU_RESP;
            end
            CPU_RESP: begin
                cpu_valid_d = 1'b1;
                state_d     = IDLE;
            end
            CTX_SAVE: begin
                mem_we     = 1'b1;
                mem_addr   = AW'(CTX_SLOT);
                mem_wdata  = end_atual;
                saida_pc_d = end_atual;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_gnt_q   <= 1'b0;
            cpu_valid_q <= 1'b0;
            cpu_rdata_q <= '0;
            saida_pc_q  <= '0;
            ctx_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_gnt_q   <= cpu_gnt_d;
            cpu_valid_q <= cpu_valid_d;
            cpu_rdata_q <= cpu_rdata_d;
            saida_pc_q  <= saida_pc_d;
            ctx_busy_q  <= ctx_busy_d;
        end
    end

    assign cpu_gnt   = cpu_gnt_q;
    assign cpu_valid = cpu_valid_q;
    assign cpu_rdata = cpu_rdata_q;
    assign saida_pc  = saida_pc_q;
    assign ctx_busy  = ctx_busy_q;

endmodule
